fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the MIPS core. Owns the program counter and drives the address port of instrMem.
- Tags each returned instruction with its PC and buffers it in a 2-entry FIFO. Hands instructions to decode over a valid/ready handshake.
- Handles branch/jump redirects and halt, and discards stale in-flight reads.

Parameters:
ADDR_W, 32, width of PC, imem address and out_pc
RESET_PC, 0, word address fetched first after reset
INSTR_W, 32, instruction width

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  ADDR_W  word address to instrMem
imem_instr  input  INSTR_W  instrMem read data; registered, valid one clock after imem_addr is presented
redirect_valid  input  1  branch/jump taken, one-cycle pulse
redirect_pc  input  ADDR_W  redirect target word address
halt  input  1  level; stop issuing new fetches while high
out_valid  output  1  out_instr/out_pc hold a valid instruction
out_ready  input  1  decode accepts the head entry when out_valid && out_ready
out_instr  output  INSTR_W  instruction at FIFO head
out_pc  output  ADDR_W  word address of out_instr

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values (asserted immediately, independent of clk):
  - fetch_pc=RESET_PC, state=BOOT
  - FIFO count=0, pending=0
  - out_valid=0, out_instr=0, out_pc=0
- imem_addr = fetch_pc at all times (combinational from the register).
- State machine, states BOOT, RUN, HALTED:
  - BOOT: no issue; next state RUN on the first posedge with rst_n high.
  - RUN: go to HALTED when halt=1 and redirect_valid=0.
  - HALTED: no issue; return to RUN when halt=0. In-flight response and FIFO contents are still delivered.
- pop = out_valid && out_ready.
- issue = (state==RUN) && !halt && !redirect_valid && (count + pending - pop) < 2.
- On issue:
  - pending<=1, pend_pc<=fetch_pc, fetch_pc<=fetch_pc+1.
  - The add is modulo 2^ADDR_W: all-ones wraps to 0.
- Cycle after issue:
  - imem_instr is pushed to the FIFO tagged with pend_pc.
  - pending clears unless a new issue occurs the same cycle.
- Latency: an instruction is visible on out_* one cycle after its response, i.e. 2 cycles after issue.
  - With out_ready held at 1, throughput is one instruction per cycle after the pipeline fills.
  - The first out_valid=1 appears on the 3rd posedge after BOOT exits.
- FIFO: 2 entries, in-order.
  - Push and pop in the same cycle are legal at any count.
  - The credit rule makes overflow impossible; assert count<=2.
  - out_valid = (count != 0).
  - Head entry and out_* are stable while out_valid && !out_ready.
- Redirect (redirect_valid=1 in any non-BOOT state):
  - fetch_pc <= redirect_pc.
  - FIFO is flushed (count<=0, out_valid=0 next cycle); a pop in the same cycle is still counted as consumed.
  - Any pending response is killed: it arrives next cycle but is not pushed.
  - No issue occurs in the redirect cycle; the redirect target is issued the following cycle if RUN && !halt.
  - A redirect while HALTED updates fetch_pc and flushes, and stays HALTED.
- Redirect has priority over halt and over normal issue. Back-to-back redirects: the last one wins.
- Reset mid-operation: all state returns to reset values asynchronously; in-flight data is dropped.

Test Plan:
- Sequential fetch: mem[i]=0x1000_0000+i, out_ready=1 after reset → out_pc 0,1,2,3,4 on consecutive cycles with out_instr 0x10000000..0x10000004; first out_valid on the 3rd posedge after BOOT.
- Backpressure: out_ready=0 for 5 cycles once out_pc=2 → out_pc/out_instr hold at 2/0x10000002; at most 2 entries buffered; after release the stream continues 2,3,4 with no gap or duplicate.
- Redirect: pulse redirect_valid with redirect_pc=8 while pc 5 is pending and pc 4 is in the FIFO → pc 4 and 5 never appear after the redirect cycle; next out_pc=8, then 9.
- Halt: halt=1 for 4 cycles → already-fetched entries drain, then out_valid=0 and imem_addr is constant; on halt=0 fetch resumes at the next sequential PC.
- Wrap and priority: RESET_PC=0xFFFF_FFFF → out_pc FFFFFFFF then 00000000. halt=1 and redirect_valid=1 in the same cycle → fetch_pc=redirect_pc, state HALTED.
- Reset mid-stream: drop rst_n at arbitrary cycle → out_valid=0 immediately (asynchronous); after release the stream restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
//   Owns the program counter, presents it to the instruction memory, tags
//   each returned word with the PC it was fetched from and queues it in a
//   2-entry FIFO that feeds decode over a valid/ready handshake.
//   Branch/jump redirects flush the FIFO and kill the in-flight read; halt
//   stops new fetches while letting already-fetched work drain.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   imem_addr      word address to instruction memory (= fetch_pc)
//   imem_instr     instruction memory read data, one clock after imem_addr
//   redirect_valid branch/jump taken pulse
//   redirect_pc    redirect target word address
//   halt           level, blocks new fetches while high
//   out_valid      FIFO head holds a valid instruction
//   out_ready      decode accepts the head entry
//   out_instr      instruction at FIFO head
//   out_pc         word address of out_instr
module fetch_ctrl #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]         state;
  logic [ADDR_W-1:0]  fetch_pc;
  logic               pending;
  logic [ADDR_W-1:0]  pend_pc;

  logic [1:0]         count;
  logic               wr_ptr;
  logic               rd_ptr;
  logic [INSTR_W-1:0] fifo_instr [2];
  logic [ADDR_W-1:0]  fifo_pc    [2];

  logic               pop;
  logic               flush;
  logic               push;
  logic               issue;
  logic [2:0]         credit;

  assign imem_addr = fetch_pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = fifo_instr[rd_ptr];
  assign out_pc    = fifo_pc[rd_ptr];

  assign pop   = out_valid && out_ready;
  assign flush = redirect_valid && (state != BOOT);
  // The response of a read pending during a redirect belongs to the old path.
  assign push  = pending && !flush;

  // Entries that will occupy the FIFO once the pending read lands, net of the
  // current pop. Issuing only below 2 makes FIFO overflow impossible.
  assign credit = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
  assign issue  = (state == RUN) && !halt && !redirect_valid && (credit < 3'd2);

  // Stage 0: sequencer state and PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      pending  <= 1'b0;
      pend_pc  <= '0;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (halt && !redirect_valid) state <= HALTED;
        HALTED:  if (!halt) state <= RUN;
        default: state <= BOOT;
      endcase

      if (flush) begin
        fetch_pc <= redirect_pc;
      end else if (issue) begin
        fetch_pc <= fetch_pc + 1'b1;
      end

      pending <= issue;
      if (issue) begin
        pend_pc <= fetch_pc;
      end
    end
  end

  // Stage 1: response capture into the output FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= imem_instr;
        fifo_pc[wr_ptr]    <= pend_pc;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= 2'd2);

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_pc;

  logic [31:0] imem_addr_b, imem_instr_b, out_instr_b, out_pc_b;
  logic        out_valid_b;

  int n_pass = 0;
  int n_total = 0;
  int pops_a = 0;
  int pops_b = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0), .INSTR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFF), .INSTR_W(32)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr_b), .imem_instr(imem_instr_b),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .halt(1'b0),
    .out_valid(out_valid_b), .out_ready(1'b1), .out_instr(out_instr_b), .out_pc(out_pc_b)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  // Registered instruction memory: data one clock after the address.
  always @(posedge clk) begin
    imem_instr   <= memf(imem_addr);
    imem_instr_b <= memf(imem_addr_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_addr", imem_addr, 32'h0);
    check("async_rst_pc", out_pc, 32'h0);
    check("async_rst_instr", out_instr, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Stream scoreboard: every accepted instruction must be the next PC of the
  // current path, carry its own memory word, and a stalled head must hold.
  logic [31:0] exp_a;
  logic        hold;
  logic [31:0] hold_pc, hold_instr;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_a = 32'h0;
      hold  = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_pc", out_pc, hold_pc);
        check("hold_instr", out_instr, hold_instr);
      end
      if (out_valid) check("tag_instr", out_instr, memf(out_pc));
      if (out_valid && out_ready) begin
        check("stream_pc", out_pc, exp_a);
        exp_a = out_pc + 32'd1;
        pops_a++;
      end
      if (redirect_valid) exp_a = redirect_pc;
      hold       = out_valid && !out_ready && !redirect_valid;
      hold_pc    = out_pc;
      hold_instr = out_instr;
    end
  end

  logic [31:0] exp_b;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_b = 32'hFFFF_FFFF;
    end else if (out_valid_b) begin
      check("wrap_stream_pc", out_pc_b, exp_b);
      check("wrap_tag_instr", out_instr_b, memf(out_pc_b));
      exp_b = out_pc_b + 32'd1;
      pops_b++;
    end
  end

  initial begin
    logic [31:0] saved;
    bit found;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_addr_wrap", imem_addr_b, 32'hFFFF_FFFF);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Sequential fetch and first-valid latency
    tick();
    check("lat_edge1", {31'b0, out_valid}, 32'd0);
    tick();
    check("lat_edge2", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("seq_valid", {31'b0, out_valid}, 32'd1);
      check("seq_pc", out_pc, i);
      check("seq_instr", out_instr, 32'h1000_0000 + i);
      if (i == 0) check("wrap_first", out_pc_b, 32'hFFFF_FFFF);
      if (i == 1) check("wrap_second", out_pc_b, 32'h0);
    end

    // Reset mid-stream, then backpressure at pc 2
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (out_valid && out_pc == 32'd2) found = 1'b1;
    end
    check("bp_reach_pc2", {31'b0, found}, 32'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_pc", out_pc, 32'd2);
      check("bp_instr", out_instr, 32'h1000_0002);
    end
    // Two entries buffered, nothing in flight: fetch sits two past the head.
    check("bp_fetch_addr", imem_addr, 32'd4);
    out_ready = 1'b1;
    for (int i = 3; i < 6; i++) begin
      tick();
      check("bp_release_valid", {31'b0, out_valid}, 32'd1);
      check("bp_release_pc", out_pc, i);
    end

    // Redirect while pc 4 is at the head and pc 5 is in flight
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (out_valid && out_pc == 32'd4) found = 1'b1;
    end
    check("rd_reach_pc4", {31'b0, found}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'd8;
    tick();
    redirect_valid = 1'b0;
    check("rd_flushed", {31'b0, out_valid}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      if (out_valid) found = 1'b1;
      else tick();
    end
    check("rd_target_seen", {31'b0, found}, 32'd1);
    check("rd_target_pc", out_pc, 32'd8);
    tick();
    check("rd_next_pc", out_pc, 32'd9);

    // Halt for 4 cycles: drain, then fetch address frozen
    halt = 1'b1;
    saved = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) saved = imem_addr;
    end
    check("halt_drained", {31'b0, out_valid}, 32'd0);
    check("halt_addr_frozen", imem_addr, saved);
    halt = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      if (out_valid) found = 1'b1;
    end
    check("halt_resume", {31'b0, found}, 32'd1);
    check("halt_resume_pc", out_pc, saved);

    // Halt and redirect together: redirect wins, fetch stays stopped
    halt = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("hr_addr", imem_addr, 32'h40);
    for (int i = 0; i < 3; i++) tick();
    check("hr_addr_held", imem_addr, 32'h40);
    check("hr_flushed", {31'b0, out_valid}, 32'd0);
    halt = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (out_valid) found = 1'b1;
    end
    check("hr_resume", {31'b0, found}, 32'd1);
    check("hr_resume_pc", out_pc, 32'h40);

    // Randomized traffic checked by the stream scoreboard
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      tick();
    end
    redirect_valid = 1'b0;
    halt = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    check("enough_pops", {31'b0, pops_a >= 50}, 32'd1);
    check("wrap_pops", {31'b0, pops_b >= 50}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
